multi_rate_blinker: RTL and testbench

Parametrised, multi-channel programmable blinker: N_CH independent LED channels, each with its own one-hot blink-rate register and output mode. A shared prescaler generates the base tick. A single pair of slower/faster buttons plus a channel select adjusts whichever channel is addressed. It sits between the debounced board buttons and the LED pins, and supersedes the single-channel shift/timer/blink chain.

---
 rtl/blinker_pkg.sv | 19 +
 rtl/blink_channel.sv | 84 ++++++++
 rtl/multi_rate_blinker.sv | 88 ++++++++
 tb/tb_multi_rate_blinker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// blinker_pkg: shared mode encoding and reset constants for the multi-rate blinker.
// Rev 1.0
`default_nettype none

package blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BLINK_N = 2'b11
  } mode_t;

  localparam int    RATE_RST = 1;
  localparam mode_t MODE_RST = MODE_BLINK;

endpackage

`default_nettype wire

// File: rtl/blink_channel.sv
// blink_channel: one LED channel with a saturating one-hot rate register, a half-period counter and a mode.
// Rev 1.0
`default_nettype none

module blink_channel
  import blinker_pkg::*;
#(
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              inc,
  input  logic              dec,
  input  logic              mode_we,
  input  mode_t             mode_in,
  output logic [RATE_W-1:0] rate,
  output logic              light
);

  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  mode_t             mode_q, mode_d;

  always_comb begin
    rate_d  = rate_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    mode_d  = mode_q;

    if (inc && !rate_q[RATE_W-1]) begin
      rate_d = rate_q << 1;
    end else if (dec && !rate_q[0]) begin
      rate_d = rate_q >> 1;
    end

    // A real rate change restarts the half-period and takes priority over a coincident tick.
    if (rate_d != rate_q) begin
      cnt_d = rate_d;
    end else if (tick) begin
      if (cnt_q <= RATE_W'(1)) begin
        cnt_d   = rate_q;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (mode_we) begin
      mode_d = mode_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q  <= RATE_W'(RATE_RST);
      cnt_q   <= RATE_W'(1);
      phase_q <= 1'b0;
      mode_q  <= MODE_RST;
    end else begin
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    light = 1'b0;
    case (mode_q)
      MODE_OFF:     light = 1'b0;
      MODE_ON:      light = 1'b1;
      MODE_BLINK:   light = phase_q;
      MODE_BLINK_N: light = ~phase_q;
      default:      light = 1'b0;
    endcase
  end

  assign rate = rate_q;

endmodule

`default_nettype wire

// File: rtl/multi_rate_blinker.sv
// multi_rate_blinker: shared prescaler, button edge detect and channel addressing for N_CH blink channels.
// Rev 1.0
`default_nettype none

module multi_rate_blinker
  import blinker_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int RATE_W   = 4,
  parameter int PRESCALE = 1000,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_left,
  input  logic              shift_right,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              mode_wr,
  input  logic [1:0]        mode_in,
  output logic [RATE_W-1:0] rate_out,
  output logic [N_CH-1:0]   out_light
);

  localparam int                c_ps_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_ps_w-1:0] c_ps_max = c_ps_w'(PRESCALE - 1);

  logic [c_ps_w-1:0] ps_q, ps_d;
  logic [1:0]        btn_q, btn_hist_q;
  logic [1:0]        w_press;
  logic              w_tick;
  logic              w_press_l, w_press_r;
  logic              w_sel_valid;
  logic [RATE_W-1:0] w_rate [N_CH];

  assign w_tick = (ps_q == c_ps_max);
  assign ps_d   = w_tick ? '0 : ps_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q       <= '0;
      btn_q      <= '0;
      btn_hist_q <= '0;
    end else begin
      ps_q       <= ps_d;
      btn_q      <= {shift_left, shift_right};
      btn_hist_q <= btn_q;
    end
  end

  // Bit 1 is the slower button, bit 0 the faster one; coincident presses cancel.
  assign w_press     = btn_q & ~btn_hist_q;
  assign w_press_l   = w_press[1] & ~w_press[0];
  assign w_press_r   = w_press[0] & ~w_press[1];
  assign w_sel_valid = (int'(ch_sel) < N_CH);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic w_hit;
      assign w_hit = w_sel_valid && (ch_sel == CH_W'(gi));

      blink_channel #(
        .RATE_W (RATE_W)
      ) u_channel (
        .clk     (clk),
        .rst     (rst),
        .tick    (w_tick),
        .inc     (w_hit & w_press_l),
        .dec     (w_hit & w_press_r),
        .mode_we (w_hit & mode_wr),
        .mode_in (mode_t'(mode_in)),
        .rate    (w_rate[gi]),
        .light   (out_light[gi])
      );
    end
  endgenerate

  always_comb begin
    rate_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel_valid && (int'(ch_sel) == i)) begin
        rate_out = w_rate[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_rate_blinker.sv
// tb_multi_rate_blinker: directed self-checking bench for multi_rate_blinker (N_CH=2, RATE_W=4, PRESCALE=4).
// Rev 1.0
`default_nettype none

module tb_multi_rate_blinker;

  logic       clk;
  logic       rst;
  logic       shift_left;
  logic       shift_right;
  logic [1:0] ch_sel;
  logic       mode_wr;
  logic [1:0] mode_in;
  logic [3:0] rate_out;
  logic [1:0] out_light;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  multi_rate_blinker #(
    .N_CH     (2),
    .RATE_W   (4),
    .PRESCALE (4),
    .CH_W     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .ch_sel      (ch_sel),
    .mode_wr     (mode_wr),
    .mode_in     (mode_in),
    .rate_out    (rate_out),
    .out_light   (out_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Reference phase for a rate-1 channel: toggles on every 4th edge after reset release.
  function automatic logic ref_phase();
    return ((cyc / 4) % 2) == 1;
  endfunction

  task automatic do_reset;
    rst         = 1'b1;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    mode_wr     = 1'b0;
    mode_in     = 2'b00;
    ch_sel      = 2'd0;
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic measure(input int idx, output int n);
    logic prev;
    prev = out_light[idx];
    n = 0;
    do begin
      step(1);
      n++;
    end while (out_light[idx] == prev && n < 300);
    if (n >= 300) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; shift_left = 1'b0; shift_right = 1'b0;
    mode_wr = 1'b0; mode_in = 2'b00; ch_sel = 2'd0;
    #1;
    checks++; if (out_light !== 2'b00) begin errors++; $display("FAIL reset_light: got %b want 00", out_light); end
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL reset_rate: got %b want 0001", rate_out); end
    #1; rst = 1'b0; cyc = 0;
    step(3);
    checks++; if (out_light !== 2'b00) begin errors++; $display("FAIL pre_first_tick: got %b want 00", out_light); end
    step(1);
    checks++; if (out_light !== 2'b11) begin errors++; $display("FAIL first_tick: got %b want 11", out_light); end
    shift_left = 1'b1; step(1); shift_left = 1'b0; step(1);
    checks++; if (rate_out !== 4'b0010) begin errors++; $display("FAIL pre_reset_rate: got %b want 0010", rate_out); end
    checks++; if (out_light !== 2'b11) begin errors++; $display("FAIL pre_reset_light: got %b want 11", out_light); end
    rst = 1'b1;
    #1;
    checks++; if (out_light !== 2'b00) begin errors++; $display("FAIL async_clear_light: got %b want 00", out_light); end
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL async_clear_rate: got %b want 0001", rate_out); end
    #1; rst = 1'b0; cyc = 0;
    step(3);
    checks++; if (out_light !== 2'b00) begin errors++; $display("FAIL restart_pre_tick: got %b want 00", out_light); end
    step(1);
    checks++; if (out_light !== 2'b11) begin errors++; $display("FAIL restart_tick: got %b want 11", out_light); end
  endtask

  task automatic test_default_blink;
    logic [1:0] exp;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step(1);
      exp = ref_phase() ? 2'b11 : 2'b00;
      checks++; if (out_light !== exp) begin errors++; $display("FAIL default_blink cyc %0d: got %b want %b", cyc, out_light, exp); end
    end
  endtask

  task automatic test_slower;
    logic [3:0] exp_rate [4];
    int h0, h1, h2;
    exp_rate[0] = 4'b0010; exp_rate[1] = 4'b0100;
    exp_rate[2] = 4'b1000; exp_rate[3] = 4'b1000;
    do_reset();
    ch_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      shift_left = 1'b1; step(1); shift_left = 1'b0; step(1);
      checks++; if (rate_out !== exp_rate[i]) begin errors++; $display("FAIL slower_step%0d: got %b want %b", i, rate_out, exp_rate[i]); end
    end
    measure(0, h0); measure(0, h1); measure(0, h2);
    checks++; if (h1 + h2 !== 64) begin errors++; $display("FAIL ch0_period: got %0d want 64", h1 + h2); end
    measure(1, h0); measure(1, h1); measure(1, h2);
    checks++; if (h1 + h2 !== 8) begin errors++; $display("FAIL ch1_period: got %0d want 8", h1 + h2); end
  endtask

  task automatic test_buttons;
    do_reset();
    ch_sel = 2'd0;
    shift_right = 1'b1; step(1); shift_right = 1'b0; step(1);
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL right_sat: got %b want 0001", rate_out); end
    shift_left = 1'b1; step(1); shift_left = 1'b0; step(1);
    checks++; if (rate_out !== 4'b0010) begin errors++; $display("FAIL left_once: got %b want 0010", rate_out); end
    shift_left = 1'b1; shift_right = 1'b1; step(1);
    shift_left = 1'b0; shift_right = 1'b0; step(2);
    checks++; if (rate_out !== 4'b0010) begin errors++; $display("FAIL both_ignored: got %b want 0010", rate_out); end
    shift_left = 1'b1; step(10);
    checks++; if (rate_out !== 4'b0100) begin errors++; $display("FAIL held: got %b want 0100", rate_out); end
    shift_left = 1'b0; step(2);
    checks++; if (rate_out !== 4'b0100) begin errors++; $display("FAIL held_release: got %b want 0100", rate_out); end
    shift_right = 1'b1; step(1); shift_right = 1'b0; step(1);
    checks++; if (rate_out !== 4'b0010) begin errors++; $display("FAIL right_halves: got %b want 0010", rate_out); end
    ch_sel = 2'd1; #1;
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL ch1_untouched: got %b want 0001", rate_out); end
  endtask

  task automatic test_modes;
    logic [1:0] seq [4];
    logic       exp1;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    do_reset();
    ch_sel = 2'd1;
    step(2);
    for (int m = 0; m < 4; m++) begin
      mode_in = seq[m]; mode_wr = 1'b1; step(1); mode_wr = 1'b0;
      for (int j = 0; j < 8; j++) begin
        case (seq[m])
          2'b00:   exp1 = 1'b0;
          2'b01:   exp1 = 1'b1;
          2'b11:   exp1 = ~ref_phase();
          default: exp1 = ref_phase();
        endcase
        checks++; if (out_light[1] !== exp1) begin errors++; $display("FAIL mode%b_ch1 cyc %0d: got %b want %b", seq[m], cyc, out_light[1], exp1); end
        checks++; if (out_light[0] !== ref_phase()) begin errors++; $display("FAIL mode%b_ch0 cyc %0d: got %b want %b", seq[m], cyc, out_light[0], ref_phase()); end
        step(1);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [1:0] exp;
    do_reset();
    ch_sel = 2'd3; #1;
    checks++; if (rate_out !== 4'b0000) begin errors++; $display("FAIL oor_rate3: got %b want 0000", rate_out); end
    ch_sel = 2'd2; #1;
    checks++; if (rate_out !== 4'b0000) begin errors++; $display("FAIL oor_rate2: got %b want 0000", rate_out); end
    ch_sel = 2'd3;
    shift_left = 1'b1; mode_in = 2'b00; mode_wr = 1'b1; step(1);
    shift_left = 1'b0; mode_wr = 1'b0; step(2);
    ch_sel = 2'd0; #1;
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL oor_ch0_rate: got %b want 0001", rate_out); end
    ch_sel = 2'd1; #1;
    checks++; if (rate_out !== 4'b0001) begin errors++; $display("FAIL oor_ch1_rate: got %b want 0001", rate_out); end
    for (int j = 0; j < 8; j++) begin
      step(1);
      exp = ref_phase() ? 2'b11 : 2'b00;
      checks++; if (out_light !== exp) begin errors++; $display("FAIL oor_light cyc %0d: got %b want %b", cyc, out_light, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_default_blink();
    test_slower();
    test_buttons();
    test_modes();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
